i2c_regfile_p: RTL and testbench

I2C_REGFILE_P -- requirements
Module: i2c_regfile_p

---
 rtl/i2c_regfile_p_if.sv | 16 +
 rtl/i2c_regfile_p.sv | 267 ++++++++++++++++++++++++++
 tb/tb_i2c_regfile_p.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_regfile_p_if.sv
// APB bus bundle between the host bridge and the I2C register file.
interface i2c_regfile_p_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/i2c_regfile_p.sv
// I2C controller register file: APB slave with interrupt status/enable,
// FIFO data ports, address/control/timing registers and a soft-reset pulser.

// One interrupt status bit: edge- or level-sensitive set, W1C clear.
module i2c_regfile_p_isr_bit (
    input  logic clk,
    input  logic rstn,
    input  logic i_req,
    input  logic i_mode,
    input  logic i_clr,
    output logic o_isr
);
    logic r_prev;
    logic r_isr;
    logic w_set;

    // edge mode sets on a 0->1 transition, level mode sets every cycle high
    assign w_set = i_mode ? (i_req & ~r_prev) : i_req;

    // request history for edge detect; a set beats a same-cycle clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev <= 1'b0;
            r_isr  <= 1'b0;
        end else begin
            r_prev <= i_req;
            r_isr  <= (r_isr & ~i_clr) | w_set;
        end
    end

    assign o_isr = r_isr;
endmodule

module i2c_regfile_p #(
    parameter int unsigned NIRQ     = 8,
    parameter int unsigned FIFO_AW  = 4,
    parameter int unsigned TW       = 32,
    parameter int unsigned SRST_CYC = 10,
    parameter logic [31:0] TDEF     = '0
) (
    input  logic                clk,
    input  logic                rstn,
    i2c_regfile_p_if.slave      apb,
    output logic                irq,
    input  logic [NIRQ-1:0]     irq_req,
    input  logic [FIFO_AW:0]    tx_fifo_ocy,
    input  logic [FIFO_AW:0]    rx_fifo_ocy,
    output logic                tx_fifo_wr,
    output logic [9:0]          tx_fifo_wdat,
    output logic                rx_fifo_rd,
    input  logic [7:0]          rx_fifo_rdat,
    output logic [FIFO_AW:0]    rx_fifo_pirq,
    output logic [9:0]          slv_adr,
    output logic                srstn,
    output logic [6:0]          cr,
    input  logic [7:0]          sr,
    output logic [TW-1:0]       tsusta,
    output logic [TW-1:0]       tsusto,
    output logic [TW-1:0]       thdsta,
    output logic [TW-1:0]       tsudat,
    output logic [TW-1:0]       tbuf,
    output logic [TW-1:0]       thigh,
    output logic [TW-1:0]       tlow
);
    localparam int unsigned OW    = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    // word addresses (byte address >> 2)
    localparam logic [9:0] A_GIE   = 10'h007;
    localparam logic [9:0] A_ISR   = 10'h008;
    localparam logic [9:0] A_IMODE = 10'h009;
    localparam logic [9:0] A_IER   = 10'h00A;
    localparam logic [9:0] A_SOFTR = 10'h010;
    localparam logic [9:0] A_CR    = 10'h040;
    localparam logic [9:0] A_SR    = 10'h041;
    localparam logic [9:0] A_TXD   = 10'h042;
    localparam logic [9:0] A_RXD   = 10'h043;
    localparam logic [9:0] A_ADR   = 10'h044;
    localparam logic [9:0] A_TXOCY = 10'h045;
    localparam logic [9:0] A_RXOCY = 10'h046;
    localparam logic [9:0] A_TEN   = 10'h047;
    localparam logic [9:0] A_PIRQ  = 10'h048;
    localparam logic [9:0] A_TIM0  = 10'h04A;
    localparam logic [9:0] A_TIM6  = 10'h050;

    localparam logic [31:0] SOFTR_KEY = 32'h0000_000A;

    logic              r_gie;
    logic [NIRQ-1:0]   r_imode;
    logic [NIRQ-1:0]   r_ier;
    logic [6:0]        r_cr;
    logic [7:1]        r_adr;
    logic [2:0]        r_ten;
    logic [OW-1:0]     r_pirq;
    logic [TW-1:0]     r_tim [7];
    logic [31:0]       r_prdata;
    logic              r_pslverr;
    logic              r_tx_wr;
    logic [9:0]        r_tx_wdat;
    logic              r_rx_rd;
    logic              r_irq;
    logic [7:0]        r_srst_cnt;

    logic [9:0]        w_word;
    logic              w_setup;
    logic              w_acc;
    logic              w_wen;
    logic              w_tim;
    logic [2:0]        w_tidx;
    logic              w_hit;
    logic              w_ro;
    logic              w_wo;
    logic              w_err;
    logic [31:0]       w_rdata;
    logic [NIRQ-1:0]   w_isr;
    logic [NIRQ-1:0]   w_isr_clr;
    logic              w_unused_paddr;

    assign w_word         = apb.paddr[11:2];
    assign w_unused_paddr = ^apb.paddr[1:0];
    assign w_setup        = apb.psel & ~apb.penable;
    assign w_acc          = apb.psel &  apb.penable;
    // errored transfers were flagged in setup and must not touch state
    assign w_wen          = w_acc & apb.pwrite & ~r_pslverr;
    assign w_tim          = (w_word >= A_TIM0) && (w_word <= A_TIM6);
    assign w_tidx         = 3'(w_word - A_TIM0);

    // address decode and read mux from current register values
    always_comb begin
        w_hit   = 1'b1;
        w_ro    = 1'b0;
        w_wo    = 1'b0;
        w_rdata = '0;
        case (w_word)
            A_GIE:   w_rdata[0]        = r_gie;
            A_ISR:   w_rdata[NIRQ-1:0] = w_isr;
            A_IMODE: w_rdata[NIRQ-1:0] = r_imode;
            A_IER:   w_rdata[NIRQ-1:0] = r_ier;
            A_SOFTR: w_wo              = 1'b1;
            A_CR:    w_rdata[6:0]      = r_cr;
            A_SR: begin
                w_ro         = 1'b1;
                w_rdata[7:0] = sr;
            end
            A_TXD:   w_wo              = 1'b1;
            A_RXD: begin
                w_ro         = 1'b1;
                w_rdata[7:0] = rx_fifo_rdat;
            end
            A_ADR:   w_rdata[7:1]      = r_adr;
            A_TXOCY: begin
                w_ro            = 1'b1;
                w_rdata[OW-1:0] = tx_fifo_ocy;
            end
            A_RXOCY: begin
                w_ro            = 1'b1;
                w_rdata[OW-1:0] = rx_fifo_ocy;
            end
            A_TEN:   w_rdata[2:0]      = r_ten;
            A_PIRQ:  w_rdata[OW-1:0]   = r_pirq;
            default: begin
                if (w_tim) w_rdata[TW-1:0] = r_tim[w_tidx];
                else       w_hit           = 1'b0;
            end
        endcase
    end

    // any reason to reject the transfer, judged once in the setup phase
    assign w_err = ~w_hit
                 | ( apb.pwrite & w_ro)
                 | (~apb.pwrite & w_wo)
                 | ( apb.pwrite & (w_word == A_SOFTR) & (apb.pwdata != SOFTR_KEY))
                 | ( apb.pwrite & (w_word == A_TXD)   & (tx_fifo_ocy == OW'(DEPTH)))
                 | (~apb.pwrite & (w_word == A_RXD)   & (rx_fifo_ocy == '0));

    // setup-phase capture of response data, error and FIFO strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            r_tx_wr   <= 1'b0;
            r_tx_wdat <= '0;
            r_rx_rd   <= 1'b0;
        end else begin
            r_tx_wr <= 1'b0;
            r_rx_rd <= 1'b0;
            if (w_setup) begin
                r_pslverr <= w_err;
                r_prdata  <= w_err ? '0 : w_rdata;
                r_tx_wr   <= ~w_err &  apb.pwrite & (w_word == A_TXD);
                r_rx_rd   <= ~w_err & ~apb.pwrite & (w_word == A_RXD);
                if (~w_err & apb.pwrite & (w_word == A_TXD))
                    r_tx_wdat <= apb.pwdata[9:0];
            end else if (!apb.psel) begin
                r_pslverr <= 1'b0;
            end
        end
    end

    // software-writable configuration registers, updated at end of access
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gie   <= 1'b0;
            r_imode <= '0;
            r_ier   <= '0;
            r_cr    <= '0;
            r_adr   <= '0;
            r_ten   <= '0;
            r_pirq  <= '0;
            for (int k = 0; k < 7; k++) r_tim[k] <= TDEF[TW-1:0];
        end else if (w_wen) begin
            case (w_word)
                A_GIE:   r_gie   <= apb.pwdata[0];
                A_IMODE: r_imode <= apb.pwdata[NIRQ-1:0];
                A_IER:   r_ier   <= apb.pwdata[NIRQ-1:0];
                A_CR:    r_cr    <= apb.pwdata[6:0];
                A_ADR:   r_adr   <= apb.pwdata[7:1];
                A_TEN:   r_ten   <= apb.pwdata[2:0];
                A_PIRQ:  r_pirq  <= apb.pwdata[OW-1:0];
                default: if (w_tim) r_tim[w_tidx] <= apb.pwdata[TW-1:0];
            endcase
        end
    end

    assign w_isr_clr = (w_wen && (w_word == A_ISR)) ? apb.pwdata[NIRQ-1:0] : '0;

    i2c_regfile_p_isr_bit u_isr [NIRQ-1:0] (
        .clk    (clk),
        .rstn   (rstn),
        .i_req  (irq_req),
        .i_mode (r_imode),
        .i_clr  (w_isr_clr),
        .o_isr  (w_isr)
    );

    // registered interrupt line, lags ISR/IER/GIE by one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_irq <= 1'b0;
        else       r_irq <= r_gie & (|(w_isr & r_ier));
    end

    // soft-reset down-counter; a fresh key write reloads the full length
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                r_srst_cnt <= '0;
        else if (w_wen && (w_word == A_SOFTR))    r_srst_cnt <= 8'(SRST_CYC);
        else if (r_srst_cnt != '0)                r_srst_cnt <= r_srst_cnt - 8'd1;
    end

    assign srstn        = (r_srst_cnt == '0);
    assign apb.pready   = 1'b1;
    assign apb.prdata   = r_prdata;
    assign apb.pslverr  = r_pslverr;
    assign irq          = r_irq;
    assign tx_fifo_wr   = r_tx_wr;
    assign tx_fifo_wdat = r_tx_wdat;
    assign rx_fifo_rd   = r_rx_rd;
    assign rx_fifo_pirq = r_pirq;
    assign slv_adr      = {r_ten, r_adr};
    assign cr           = r_cr;
    assign tsusta       = r_tim[0];
    assign tsusto       = r_tim[1];
    assign thdsta       = r_tim[2];
    assign tsudat       = r_tim[3];
    assign tbuf         = r_tim[4];
    assign thigh        = r_tim[5];
    assign tlow         = r_tim[6];
endmodule

// File: tb/tb_i2c_regfile_p.sv
// Randomised + directed bench for i2c_regfile_p with a scoreboard and a
// cycle-level behavioural model of the register file.
module tb_i2c_regfile_p;
    localparam int NIRQ     = 8;
    localparam int FIFO_AW  = 4;
    localparam int OW       = 5;
    localparam int DEPTH    = 16;
    localparam int TW       = 16;
    localparam int SRST_CYC = 10;
    localparam logic [31:0] TDEF = 32'h0000_ABCD;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    i2c_regfile_p_if bus();

    logic            irq;
    logic [NIRQ-1:0] irq_req      = '0;
    logic [OW-1:0]   tx_fifo_ocy  = '0;
    logic [OW-1:0]   rx_fifo_ocy  = '0;
    logic            tx_fifo_wr;
    logic [9:0]      tx_fifo_wdat;
    logic            rx_fifo_rd;
    logic [7:0]      rx_fifo_rdat = '0;
    logic [OW-1:0]   rx_fifo_pirq;
    logic [9:0]      slv_adr;
    logic            srstn;
    logic [6:0]      cr;
    logic [7:0]      sr = '0;
    logic [TW-1:0]   tsusta, tsusto, thdsta, tsudat, tbuf, thigh, tlow;

    i2c_regfile_p #(.NIRQ(NIRQ), .FIFO_AW(FIFO_AW), .TW(TW),
                    .SRST_CYC(SRST_CYC), .TDEF(TDEF)) dut (
        .clk(clk), .rstn(rstn), .apb(bus), .irq(irq), .irq_req(irq_req),
        .tx_fifo_ocy(tx_fifo_ocy), .rx_fifo_ocy(rx_fifo_ocy),
        .tx_fifo_wr(tx_fifo_wr), .tx_fifo_wdat(tx_fifo_wdat),
        .rx_fifo_rd(rx_fifo_rd), .rx_fifo_rdat(rx_fifo_rdat),
        .rx_fifo_pirq(rx_fifo_pirq), .slv_adr(slv_adr), .srstn(srstn),
        .cr(cr), .sr(sr), .tsusta(tsusta), .tsusto(tsusto), .thdsta(thdsta),
        .tsudat(tsudat), .tbuf(tbuf), .thigh(thigh), .tlow(tlow)
    );

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        logic        txwr;
        logic [9:0]  wdat;
        logic        rxrd;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic            m_gie;
    logic [NIRQ-1:0] m_isr, m_imode, m_ier, m_prev;
    logic [6:0]      m_cr;
    logic [6:0]      m_adr;
    logic [2:0]      m_ten;
    logic [OW-1:0]   m_pirq;
    logic [TW-1:0]   m_tim [7];
    logic            m_irq;
    int              m_cnt;
    logic            pend_wr = 1'b0;
    logic [9:0]      pend_word = '0;
    logic [31:0]     pend_data = '0;

    logic [NIRQ-1:0] irq_dir  = '0;
    logic            rand_irq = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // interrupt sources change mid-cycle, away from edges and bus drive
    always @(posedge clk) begin
        #2;
        irq_req = rand_irq ? (NIRQ'($urandom) & NIRQ'($urandom)) : irq_dir;
    end

    // model advances one clock: irq from old state, then ISR and write
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_gie = 0; m_isr = '0; m_imode = '0; m_ier = '0; m_prev = '0;
            m_cr = '0; m_adr = '0; m_ten = '0; m_pirq = '0; m_irq = 0;
            m_cnt = 0; pend_wr = 0;
            for (int k = 0; k < 7; k++) m_tim[k] = TDEF[TW-1:0];
        end else begin
            logic [NIRQ-1:0] setv;
            logic [NIRQ-1:0] clrv;
            m_irq = m_gie && ((m_isr & m_ier) != '0);
            clrv = '0;
            if (m_cnt > 0) m_cnt--;
            for (int i = 0; i < NIRQ; i++)
                setv[i] = m_imode[i] ? (irq_req[i] && !m_prev[i]) : irq_req[i];
            m_prev = irq_req;
            if (pend_wr) begin
                case (pend_word)
                    10'h007: m_gie   = pend_data[0];
                    10'h008: clrv    = pend_data[NIRQ-1:0];
                    10'h009: m_imode = pend_data[NIRQ-1:0];
                    10'h00A: m_ier   = pend_data[NIRQ-1:0];
                    10'h010: m_cnt   = SRST_CYC;
                    10'h040: m_cr    = pend_data[6:0];
                    10'h044: m_adr   = pend_data[7:1];
                    10'h047: m_ten   = pend_data[2:0];
                    10'h048: m_pirq  = pend_data[OW-1:0];
                    default: if (pend_word >= 10'h04A && pend_word <= 10'h050)
                                 m_tim[pend_word - 10'h04A] = pend_data[TW-1:0];
                endcase
                pend_wr = 0;
            end
            m_isr = (m_isr & ~clrv) | setv;
        end
    end

    // expected response of a transfer issued against the current model state
    function automatic void mexp(input logic wr, input logic [11:0] a, input logic [31:0] d,
                                 output logic err, output logic [31:0] rd);
        logic [9:0] w;
        logic hit, ro, wo;
        w = a[11:2]; hit = 1; ro = 0; wo = 0; rd = '0;
        case (w)
            10'h007: rd = 32'(m_gie);
            10'h008: rd = 32'(m_isr);
            10'h009: rd = 32'(m_imode);
            10'h00A: rd = 32'(m_ier);
            10'h010: wo = 1;
            10'h040: rd = 32'(m_cr);
            10'h041: begin ro = 1; rd = 32'(sr); end
            10'h042: wo = 1;
            10'h043: begin ro = 1; rd = 32'(rx_fifo_rdat); end
            10'h044: rd = 32'({m_adr, 1'b0});
            10'h045: begin ro = 1; rd = 32'(tx_fifo_ocy); end
            10'h046: begin ro = 1; rd = 32'(rx_fifo_ocy); end
            10'h047: rd = 32'(m_ten);
            10'h048: rd = 32'(m_pirq);
            10'h04A, 10'h04B, 10'h04C, 10'h04D, 10'h04E, 10'h04F, 10'h050:
                     rd = 32'(m_tim[w - 10'h04A]);
            default: hit = 0;
        endcase
        err = !hit || (wr && ro) || (!wr && wo)
           || (wr && w == 10'h010 && d != 32'hA)
           || (wr && w == 10'h042 && 32'(tx_fifo_ocy) == DEPTH)
           || (!wr && w == 10'h043 && rx_fifo_ocy == '0);
        if (err) rd = '0;
    endfunction

    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        logic err;
        logic [31:0] rd;
        @(posedge clk); #1;
        bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
        mexp(wr, a, d, err, rd);
        e.err = err; e.chk_rd = !wr; e.rd = rd;
        e.txwr = wr && !err && a[11:2] == 10'h042;
        e.wdat = d[9:0];
        e.rxrd = !wr && !err && a[11:2] == 10'h043;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.penable = 1;
        if (wr && !err) begin pend_word = a[11:2]; pend_data = d; pend_wr = 1; end
        @(posedge clk); #1;
        bus.psel = 0; bus.penable = 0;
    endtask

    // monitor: continuous output compare plus scoreboard pop per access phase
    always @(negedge clk) begin
        exp_t e;
        logic [TW-1:0] tv [7];
        chk("srstn", 32'(srstn), 32'(m_cnt == 0));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("cr", 32'(cr), 32'(m_cr));
        chk("slv_adr", 32'(slv_adr), 32'({m_ten, m_adr}));
        chk("rx_fifo_pirq", 32'(rx_fifo_pirq), 32'(m_pirq));
        tv = '{tsusta, tsusto, thdsta, tsudat, tbuf, thigh, tlow};
        for (int k = 0; k < 7; k++) chk("timing_reg", 32'(tv[k]), 32'(m_tim[k]));
        if (bus.psel && bus.penable) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: access phase with no expectation at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("pready", 32'(bus.pready), 32'd1);
                chk("pslverr", 32'(bus.pslverr), 32'(e.err));
                if (e.chk_rd) chk("prdata", bus.prdata, e.rd);
                chk("tx_fifo_wr", 32'(tx_fifo_wr), 32'(e.txwr));
                if (e.txwr) chk("tx_fifo_wdat", 32'(tx_fifo_wdat), 32'(e.wdat));
                chk("rx_fifo_rd", 32'(rx_fifo_rd), 32'(e.rxrd));
            end
        end else begin
            chk("tx_fifo_wr_idle", 32'(tx_fifo_wr), 32'd0);
            chk("rx_fifo_rd_idle", 32'(rx_fifo_rd), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [11:0] alist [21] = '{12'h01C, 12'h020, 12'h024, 12'h028, 12'h040, 12'h100,
                                12'h104, 12'h108, 12'h10C, 12'h110, 12'h114, 12'h118,
                                12'h11C, 12'h120, 12'h128, 12'h12C, 12'h130, 12'h134,
                                12'h138, 12'h13C, 12'h140};

    initial begin
        int lowcnt;
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
        repeat (3) @(posedge clk);
        #3 rstn = 1;

        // reset values
        apb(0, 12'h128, 0); chk("reset_tsusta", bus.prdata, 32'h0000_ABCD);
        apb(0, 12'h100, 0); chk("reset_cr", bus.prdata, 32'h0);

        // CR write/read
        apb(1, 12'h100, 32'h5A); apb(0, 12'h100, 0); chk("cr_rd", bus.prdata, 32'h5A);
        apb(1, 12'h110, 32'hFF); apb(0, 12'h110, 0); chk("adr_rd", bus.prdata, 32'hFE);
        apb(1, 12'h13C, 32'hDEAD_BEEF); apb(0, 12'h13C, 0); chk("thigh_rd", bus.prdata, 32'hBEEF);

        // edge-mode interrupt and W1C clear
        apb(1, 12'h024, 32'h04); apb(1, 12'h028, 32'h04);
        apb(1, 12'h020, 32'hFF); apb(1, 12'h01C, 32'h1);
        irq_dir = 8'h04;
        repeat (3) @(posedge clk);
        #1 irq_dir = 8'h00;
        repeat (2) @(posedge clk);
        apb(0, 12'h020, 0); chk("isr_edge", bus.prdata, 32'h04);
        chk("irq_set", 32'(irq), 32'd1);
        apb(1, 12'h020, 32'h04);
        chk("irq_lag", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_clr", 32'(irq), 32'd0);

        // level mode: set wins over clear
        apb(1, 12'h024, 32'h00);
        irq_dir = 8'h01;
        repeat (2) @(posedge clk);
        apb(1, 12'h020, 32'h01);
        apb(0, 12'h020, 0); chk("isr_set_wins", bus.prdata, 32'h01);
        irq_dir = 8'h00;
        repeat (2) @(posedge clk);
        apb(1, 12'h020, 32'hFF);

        // FIFO boundary cases
        tx_fifo_ocy = 5'd16; apb(1, 12'h108, 32'h1FF);
        tx_fifo_ocy = 5'd3;  apb(1, 12'h108, 32'h2A5);
        rx_fifo_ocy = 5'd0;  apb(0, 12'h10C, 0);
        rx_fifo_ocy = 5'd2; rx_fifo_rdat = 8'h3C; apb(0, 12'h10C, 0);
        chk("rxd_rd", bus.prdata, 32'h3C);

        // error cases
        apb(0, 12'h3FC, 0); chk("unmapped_rd", bus.prdata, 32'h0);
        apb(1, 12'h3FC, 32'hFFFF_FFFF);
        apb(1, 12'h104, 32'h55);
        apb(0, 12'h040, 0);
        apb(0, 12'h108, 0);

        // soft reset restart
        lowcnt = 0;
        fork
            begin
                repeat (40) begin @(negedge clk); if (!srstn) lowcnt++; end
            end
            begin
                apb(1, 12'h040, 32'hA);
                repeat (2) @(posedge clk);
                apb(1, 12'h040, 32'hA);
            end
        join
        chk("srstn_low_cycles", 32'(lowcnt), 32'(5 + SRST_CYC));
        apb(1, 12'h040, 32'hB);

        // hard reset aborts an active soft-reset pulse
        apb(1, 12'h040, 32'hA);
        repeat (3) @(posedge clk);
        #3 chk("srstn_active", 32'(srstn), 32'd0);
        rstn = 0;
        #1 chk("srstn_abort", 32'(srstn), 32'd1);
        repeat (2) @(posedge clk);
        #3 rstn = 1;
        apb(0, 12'h100, 0); chk("cr_after_rst", bus.prdata, 32'h0);
        apb(0, 12'h13C, 0); chk("thigh_after_rst", bus.prdata, 32'hABCD);

        // random traffic
        rand_irq = 1;
        repeat (300) begin
            logic [11:0] a;
            logic wr;
            logic [31:0] d;
            int k;
            k = int'($urandom_range(0, 23));
            a = (k < 21) ? alist[k] : 12'($urandom);
            wr = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 12'h040 && $urandom_range(0, 1) == 1) d = 32'hA;
            tx_fifo_ocy  = OW'($urandom_range(0, 16));
            rx_fifo_ocy  = OW'($urandom_range(0, 16));
            rx_fifo_rdat = 8'($urandom);
            sr           = 8'($urandom);
            apb(wr, a, d);
        end
        rand_irq = 0;
        repeat (3) @(posedge clk);
        #1 chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
